// File: rtl/spi_ram_pkg.sv
// ============================================================================
// Module      : spi_ram_pkg
// Description : Shared command codes, FSM states and owner encoding for the
//               SPI/host RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        RD   = 2'b10
    } state_t;

    typedef enum logic {
        OWN_SPI  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

endpackage : spi_ram_pkg

`default_nettype wire

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin picker; requester 1 (host) is
//               treated as the last winner out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt
);

    logic r_last;   // 1 = requester 1 won the most recent arbitration

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_update && (|o_gnt)) begin
            r_last <= o_gnt[1];
        end
    end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/spi_ram_arbiter.sv
// ============================================================================
// Module      : spi_ram_arbiter
// Description : Decodes the SPI command stream and shares a single-port RAM
//               between SPI and a local host, one access at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256,
    parameter int DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           spi_rx_data,
    input  logic                 spi_rx_valid,
    output logic [DATA_W-1:0]    spi_tx_data,
    output logic                 spi_tx_valid,
    output logic                 spi_ovf,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [DATA_W-1:0]    host_wdata,
    output logic                 host_gnt,
    output logic [DATA_W-1:0]    host_rdata,
    output logic                 host_rvalid,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata
);

    // Addresses wrap modulo the RAM depth.
    localparam logic [ADDR_SIZE-1:0] c_ADDR_MASK = ADDR_SIZE'(MEM_DEPTH - 1);

    logic [1:0]           w_cmd;
    logic [7:0]           w_payload;
    logic                 w_enq;
    logic                 w_spi_grant;
    logic                 w_slot_avail;
    logic                 w_pick;
    logic [1:0]           w_req;
    logic [1:0]           w_gnt;
    state_t               r_state;
    state_t               w_state_nxt;
    owner_t               r_owner;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_slot_full;
    logic                 r_slot_we;
    logic [ADDR_SIZE-1:0] r_slot_addr;
    logic [DATA_W-1:0]    r_slot_wdata;

    assign w_cmd        = spi_rx_data[9:8];
    assign w_payload    = spi_rx_data[7:0];
    assign w_enq        = spi_rx_valid && ((w_cmd == CMD_WR_DATA) || (w_cmd == CMD_RD_DATA));
    // The slot is released during the SPI-owned ACC cycle, so it can refill then.
    assign w_spi_grant  = (r_state == ACC) && (r_owner == OWN_SPI);
    assign w_slot_avail = !r_slot_full || w_spi_grant;
    assign w_req        = {host_req, r_slot_full};
    assign w_pick       = (r_state == IDLE) && (|w_req);

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .i_req    (w_req),
        .i_update (w_pick),
        .o_gnt    (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pick) w_state_nxt = ACC;
            ACC:     w_state_nxt = ram_we ? IDLE : RD;
            RD:      w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= OWN_SPI;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_slot_full  <= 1'b0;
            r_slot_we    <= 1'b0;
            r_slot_addr  <= '0;
            r_slot_wdata <= '0;
            spi_ovf      <= 1'b0;
            spi_tx_data  <= '0;
            spi_tx_valid <= 1'b0;
            host_gnt     <= 1'b0;
            host_rdata   <= '0;
            host_rvalid  <= 1'b0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
        end else begin
            if (spi_rx_valid && (w_cmd == CMD_WR_ADDR)) r_wr_addr <= w_payload[ADDR_SIZE-1:0];
            if (spi_rx_valid && (w_cmd == CMD_RD_ADDR)) r_rd_addr <= w_payload[ADDR_SIZE-1:0];

            if (w_spi_grant) r_slot_full <= 1'b0;
            if (w_enq) begin
                if (w_slot_avail) begin
                    r_slot_full  <= 1'b1;
                    r_slot_we    <= (w_cmd == CMD_WR_DATA);
                    r_slot_addr  <= (w_cmd == CMD_WR_DATA) ? r_wr_addr : r_rd_addr;
                    r_slot_wdata <= w_payload[DATA_W-1:0];
                end else begin
                    spi_ovf <= 1'b1;
                end
            end

            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            host_gnt     <= 1'b0;
            spi_tx_valid <= 1'b0;
            host_rvalid  <= 1'b0;

            if (w_pick) begin
                ram_en <= 1'b1;
                if (w_gnt[1]) begin
                    r_owner   <= OWN_HOST;
                    host_gnt  <= 1'b1;
                    ram_we    <= host_we;
                    ram_addr  <= host_addr & c_ADDR_MASK;
                    ram_wdata <= host_wdata;
                end else if (w_gnt[0]) begin
                    r_owner   <= OWN_SPI;
                    ram_we    <= r_slot_we;
                    ram_addr  <= r_slot_addr & c_ADDR_MASK;
                    ram_wdata <= r_slot_wdata;
                end
            end

            if (r_state == RD) begin
                if (r_owner == OWN_SPI) begin
                    spi_tx_data  <= ram_rdata;
                    spi_tx_valid <= 1'b1;
                end else begin
                    host_rdata  <= ram_rdata;
                    host_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule : spi_ram_arbiter

`default_nettype wire

// File: tb/tb_spi_ram_arbiter.sv
// ============================================================================
// Module      : tb_spi_ram_arbiter
// Description : Directed self-checking bench for spi_ram_arbiter with a
//               one-cycle-latency RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] spi_rx_data = '0;
    logic       spi_rx_valid = 1'b0;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid;
    logic       spi_ovf;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic [7:0] mem [256];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_ram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .spi_rx_data  (spi_rx_data),
        .spi_rx_valid (spi_rx_valid),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_valid (spi_tx_valid),
        .spi_ovf      (spi_ovf),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .host_rdata   (host_rdata),
        .host_rvalid  (host_rvalid),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_en && ram_we)  mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_send(input logic [1:0] cmd, input logic [7:0] payload);
        spi_rx_valid = 1'b1;
        spi_rx_data  = {cmd, payload};
        step();
        spi_rx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ram_en"},    ram_en,       0);
        chk({tag, "_ram_we"},    ram_we,       0);
        chk({tag, "_ram_addr"},  ram_addr,     0);
        chk({tag, "_ram_wdata"}, ram_wdata,    0);
        chk({tag, "_ovf"},       spi_ovf,      0);
        chk({tag, "_tx_valid"},  spi_tx_valid, 0);
        chk({tag, "_tx_data"},   spi_tx_data,  0);
        chk({tag, "_gnt"},       host_gnt,     0);
        chk({tag, "_rvalid"},    host_rvalid,  0);
        chk({tag, "_rdata"},     host_rdata,   0);
    endtask

    initial begin
        // Reset
        step();
        step();
        rst = 1'b0;
        check_reset_outputs("rst");

        // SPI write 0x36 <= 0xAB
        spi_send(2'b00, 8'h36);
        spi_send(2'b01, 8'hAB);
        chk("wr_en_early", ram_en, 0);
        step();
        chk("wr_en",    ram_en,    1);
        chk("wr_we",    ram_we,    1);
        chk("wr_addr",  ram_addr,  8'h36);
        chk("wr_wdata", ram_wdata, 8'hAB);
        chk("wr_ovf",   spi_ovf,   0);
        step();
        chk("wr_en_off", ram_en, 0);

        // SPI read of 0x36
        spi_send(2'b10, 8'h36);
        spi_send(2'b11, 8'h00);
        step();
        chk("rd_en",   ram_en,   1);
        chk("rd_we",   ram_we,   0);
        chk("rd_addr", ram_addr, 8'h36);
        step();
        chk("rd_txv_early", spi_tx_valid, 0);
        step();
        chk("rd_txv",    spi_tx_valid, 1);
        chk("rd_txd",    spi_tx_data,  8'hAB);
        chk("rd_rvalid", host_rvalid,  0);
        step();
        chk("rd_txv_once", spi_tx_valid, 0);

        // Tie after reset: SPI first, then host wins the following tie
        rst = 1'b1;
        step();
        rst = 1'b0;
        spi_send(2'b10, 8'h36);
        spi_send(2'b11, 8'h00);
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h5A;
        step();
        chk("tie1_en",   ram_en,   1);
        chk("tie1_we",   ram_we,   0);
        chk("tie1_addr", ram_addr, 8'h36);
        chk("tie1_gnt",  host_gnt, 0);
        spi_send(2'b01, 8'hC3);           // accepted while SPI owns ACC
        chk("tie1_ovf", spi_ovf, 0);
        step();
        chk("tie1_txv", spi_tx_valid, 1);
        chk("tie1_txd", spi_tx_data,  8'hAB);
        chk("tie1_gnt_wait", host_gnt, 0);
        step();
        chk("tie2_gnt",   host_gnt,  1);
        chk("tie2_we",    ram_we,    1);
        chk("tie2_addr",  ram_addr,  8'h10);
        chk("tie2_wdata", ram_wdata, 8'h5A);
        host_req = 1'b0;
        step();
        chk("tie2_en_off", ram_en,   0);
        chk("tie2_gnt_off", host_gnt, 0);
        step();
        chk("tie3_en",    ram_en,    1);
        chk("tie3_addr",  ram_addr,  8'h00);
        chk("tie3_wdata", ram_wdata, 8'hC3);
        chk("tie3_gnt",   host_gnt,  0);
        step();

        // Overflow while host holds RAM; queued write keeps its address
        spi_send(2'b00, 8'h20);
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        spi_send(2'b01, 8'h11);
        chk("ovf_gnt", host_gnt, 1);
        host_req = 1'b0;
        spi_send(2'b00, 8'h77);
        chk("ovf_pre", spi_ovf, 0);
        spi_send(2'b01, 8'h22);
        chk("ovf_set",  spi_ovf,     1);
        chk("ovf_rv",   host_rvalid, 1);
        chk("ovf_rd",   host_rdata,  8'h5A);
        step();
        chk("ovf_wr_en",    ram_en,    1);
        chk("ovf_wr_addr",  ram_addr,  8'h20);
        chk("ovf_wr_wdata", ram_wdata, 8'h11);
        step();
        step();
        chk("ovf_sticky", spi_ovf, 1);
        chk("ovf_no_drop_wr", ram_en, 0);

        // Reset during host RD cycle
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        step();
        chk("abort_gnt", host_gnt, 1);
        host_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("abort");
        step();
        chk("abort_rv", host_rvalid, 0);

        // Back-to-back SPI write then read: ACC spacing 2 then 3
        spi_send(2'b01, 8'h5C);
        chk("b2b_c0", ram_en, 0);
        step();
        chk("b2b_c1", ram_en, 1);
        chk("b2b_wa", ram_addr, 8'h00);
        spi_send(2'b11, 8'h00);
        chk("b2b_c2", ram_en, 0);
        step();
        chk("b2b_c3", ram_en, 1);
        chk("b2b_c3we", ram_we, 0);
        spi_send(2'b01, 8'hE7);
        chk("b2b_c4", ram_en, 0);
        step();
        chk("b2b_c5", ram_en, 0);
        chk("b2b_txv", spi_tx_valid, 1);
        chk("b2b_txd", spi_tx_data, 8'h5C);
        step();
        chk("b2b_c6", ram_en, 1);
        chk("b2b_c6wd", ram_wdata, 8'hE7);
        step();
        chk("b2b_c7", ram_en, 0);
        chk("b2b_ovf", spi_ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_spi_ram_arbiter

`default_nettype wire
